bus_downsizer: RTL and testbench

BUS_DOWNSIZER -- requirements
Module: bus_downsizer

---
 rtl/bus_downsizer.sv | 263 ++++++++++++++++++++++++++
 tb/tb_bus_downsizer.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_downsizer.sv
// Wide-to-narrow Wishbone bridge: splits one 128-bit pipelined request into
// 32-bit lane transfers for the selected lanes and reassembles the read data.
module bus_downsizer #(
    parameter int unsigned AW      = 28,
    parameter int unsigned LGLANES = 2
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_s_cyc,
    input  logic                  i_s_stb,
    input  logic                  i_s_we,
    input  logic [AW-1:0]         i_s_addr,
    input  logic [127:0]          i_s_data,
    input  logic [15:0]           i_s_sel,
    output logic                  o_s_ack,
    output logic                  o_s_stall,
    output logic                  o_s_err,
    output logic [127:0]          o_s_data,
    output logic                  o_m_cyc,
    output logic                  o_m_stb,
    output logic                  o_m_we,
    output logic [AW+LGLANES-1:0] o_m_addr,
    output logic [31:0]           o_m_data,
    output logic [3:0]            o_m_sel,
    input  logic                  i_m_ack,
    input  logic                  i_m_stall,
    input  logic                  i_m_err,
    input  logic [31:0]           i_m_data
);

    localparam int unsigned NLANES = 1 << LGLANES;
    localparam int unsigned CW     = LGLANES + 1;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    // Lane 0 occupies the most significant word / sel nibble.
    function automatic logic [NLANES-1:0] sel_mask(input logic [15:0] sel);
        logic [NLANES-1:0] m;
        m = '0;
        for (int l = 0; l < int'(NLANES); l++) begin
            m[l] = |sel[(int'(NLANES) - 1 - l) * 4 +: 4];
        end
        return m;
    endfunction

    function automatic logic [LGLANES-1:0] first_lane(input logic [NLANES-1:0] m);
        logic [LGLANES-1:0] f;
        f = '0;
        for (int l = int'(NLANES) - 1; l >= 0; l--) begin
            if (m[l]) begin
                f = LGLANES'(l);
            end
        end
        return f;
    endfunction

    function automatic logic [NLANES-1:0] lane_bit(input logic [LGLANES-1:0] l);
        return NLANES'(1) << l;
    endfunction

    function automatic logic [CW-1:0] popcount(input logic [NLANES-1:0] m);
        logic [CW-1:0] c;
        c = '0;
        for (int l = 0; l < int'(NLANES); l++) begin
            c = c + CW'(m[l]);
        end
        return c;
    endfunction

    function automatic logic [31:0] lane_word(input logic [127:0] d, input logic [LGLANES-1:0] l);
        int idx;
        idx = int'(NLANES) - 1 - int'(l);
        return d[idx * 32 +: 32];
    endfunction

    function automatic logic [3:0] lane_sel(input logic [15:0] s, input logic [LGLANES-1:0] l);
        int idx;
        idx = int'(NLANES) - 1 - int'(l);
        return s[idx * 4 +: 4];
    endfunction

    function automatic logic [127:0] put_word(input logic [127:0] d, input logic [LGLANES-1:0] l,
                                              input logic [31:0] w);
        logic [127:0] r;
        int idx;
        r   = d;
        idx = int'(NLANES) - 1 - int'(l);
        r[idx * 32 +: 32] = w;
        return r;
    endfunction

    logic [0:0]            state, state_nxt;
    logic [AW-1:0]         req_addr, req_addr_nxt;
    logic [127:0]          req_data, req_data_nxt;
    logic [15:0]           req_sel, req_sel_nxt;
    logic [NLANES-1:0]     issue_mask, issue_mask_nxt;
    logic [NLANES-1:0]     ack_mask, ack_mask_nxt;
    logic [CW-1:0]         issue_cnt, issue_cnt_nxt;
    logic [CW-1:0]         ack_cnt, ack_cnt_nxt;
    logic [CW-1:0]         n_sel, n_sel_nxt;
    logic [127:0]          rdata, rdata_nxt;

    logic                  m_cyc_nxt, m_stb_nxt, m_we_nxt;
    logic [AW+LGLANES-1:0] m_addr_nxt;
    logic [31:0]           m_data_nxt;
    logic [3:0]            m_sel_nxt;
    logic                  s_ack_nxt, s_err_nxt;
    logic [127:0]          s_data_nxt;

    logic [NLANES-1:0]     in_mask;
    logic [NLANES-1:0]     issue_rem;
    logic [LGLANES-1:0]    new_lane;
    logic [LGLANES-1:0]    next_lane;
    logic [LGLANES-1:0]    ack_lane;

    assign o_s_stall = (state == BUSY);

    // Next-state and next-output logic
    always_comb begin
        state_nxt      = state;
        req_addr_nxt   = req_addr;
        req_data_nxt   = req_data;
        req_sel_nxt    = req_sel;
        issue_mask_nxt = issue_mask;
        ack_mask_nxt   = ack_mask;
        issue_cnt_nxt  = issue_cnt;
        ack_cnt_nxt    = ack_cnt;
        n_sel_nxt      = n_sel;
        rdata_nxt      = rdata;
        m_cyc_nxt      = o_m_cyc;
        m_stb_nxt      = o_m_stb;
        m_we_nxt       = o_m_we;
        m_addr_nxt     = o_m_addr;
        m_data_nxt     = o_m_data;
        m_sel_nxt      = o_m_sel;
        s_ack_nxt      = 1'b0;
        s_err_nxt      = 1'b0;
        s_data_nxt     = o_s_data;

        in_mask   = sel_mask(i_s_sel);
        new_lane  = first_lane(in_mask);
        issue_rem = issue_mask & ~lane_bit(first_lane(issue_mask));
        next_lane = first_lane(issue_rem);
        ack_lane  = first_lane(ack_mask);

        case (state)
            IDLE: begin
                if (i_s_cyc && i_s_stb) begin
                    req_addr_nxt = i_s_addr;
                    req_data_nxt = i_s_data;
                    req_sel_nxt  = i_s_sel;
                    m_we_nxt     = i_s_we;
                    if (in_mask == '0) begin
                        s_ack_nxt  = 1'b1;
                        s_data_nxt = '0;
                    end else begin
                        state_nxt      = BUSY;
                        m_cyc_nxt      = 1'b1;
                        m_stb_nxt      = 1'b1;
                        issue_mask_nxt = in_mask;
                        ack_mask_nxt   = in_mask;
                        issue_cnt_nxt  = '0;
                        ack_cnt_nxt    = '0;
                        n_sel_nxt      = popcount(in_mask);
                        rdata_nxt      = '0;
                        m_addr_nxt     = {i_s_addr, new_lane};
                        m_data_nxt     = lane_word(i_s_data, new_lane);
                        m_sel_nxt      = lane_sel(i_s_sel, new_lane);
                    end
                end
            end
            BUSY: begin
                if (!i_s_cyc) begin
                    state_nxt = IDLE;
                    m_cyc_nxt = 1'b0;
                    m_stb_nxt = 1'b0;
                end else if (i_m_err && o_m_cyc) begin
                    state_nxt = IDLE;
                    m_cyc_nxt = 1'b0;
                    m_stb_nxt = 1'b0;
                    s_err_nxt = 1'b1;
                end else begin
                    if (o_m_stb && !i_m_stall) begin
                        issue_mask_nxt = issue_rem;
                        issue_cnt_nxt  = issue_cnt + CW'(1);
                        if (issue_rem == '0) begin
                            m_stb_nxt = 1'b0;
                        end else begin
                            m_addr_nxt = {req_addr, next_lane};
                            m_data_nxt = lane_word(req_data, next_lane);
                            m_sel_nxt  = lane_sel(req_sel, next_lane);
                        end
                    end
                    // Only count acks that answer an already-issued lane
                    if (i_m_ack && o_m_cyc && (ack_cnt < issue_cnt)) begin
                        rdata_nxt    = put_word(rdata, ack_lane, i_m_data);
                        ack_mask_nxt = ack_mask & ~lane_bit(ack_lane);
                        ack_cnt_nxt  = ack_cnt + CW'(1);
                        if (ack_cnt_nxt == n_sel) begin
                            state_nxt  = IDLE;
                            m_cyc_nxt  = 1'b0;
                            m_stb_nxt  = 1'b0;
                            s_ack_nxt  = 1'b1;
                            s_data_nxt = rdata_nxt;
                        end
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                m_cyc_nxt = 1'b0;
                m_stb_nxt = 1'b0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state      <= IDLE;
            req_addr   <= '0;
            req_data   <= '0;
            req_sel    <= '0;
            issue_mask <= '0;
            ack_mask   <= '0;
            issue_cnt  <= '0;
            ack_cnt    <= '0;
            n_sel      <= '0;
            rdata      <= '0;
            o_m_cyc    <= 1'b0;
            o_m_stb    <= 1'b0;
            o_m_we     <= 1'b0;
            o_m_addr   <= '0;
            o_m_data   <= '0;
            o_m_sel    <= '0;
            o_s_ack    <= 1'b0;
            o_s_err    <= 1'b0;
            o_s_data   <= '0;
        end else begin
            state      <= state_nxt;
            req_addr   <= req_addr_nxt;
            req_data   <= req_data_nxt;
            req_sel    <= req_sel_nxt;
            issue_mask <= issue_mask_nxt;
            ack_mask   <= ack_mask_nxt;
            issue_cnt  <= issue_cnt_nxt;
            ack_cnt    <= ack_cnt_nxt;
            n_sel      <= n_sel_nxt;
            rdata      <= rdata_nxt;
            o_m_cyc    <= m_cyc_nxt;
            o_m_stb    <= m_stb_nxt;
            o_m_we     <= m_we_nxt;
            o_m_addr   <= m_addr_nxt;
            o_m_data   <= m_data_nxt;
            o_m_sel    <= m_sel_nxt;
            o_s_ack    <= s_ack_nxt;
            o_s_err    <= s_err_nxt;
            o_s_data   <= s_data_nxt;
        end
    end

endmodule

// File: tb/tb_bus_downsizer.sv
// Directed bench for bus_downsizer: a narrow-slave responder with
// programmable stall/error, plus hand-computed expectations per request.
module tb_bus_downsizer;

    localparam int unsigned AW = 28;

    logic          i_clk = 1'b0;
    logic          i_reset;
    logic          i_s_cyc, i_s_stb, i_s_we;
    logic [AW-1:0] i_s_addr;
    logic [127:0]  i_s_data;
    logic [15:0]   i_s_sel;
    logic          o_s_ack, o_s_stall, o_s_err;
    logic [127:0]  o_s_data;
    logic          o_m_cyc, o_m_stb, o_m_we;
    logic [AW+1:0] o_m_addr;
    logic [31:0]   o_m_data;
    logic [3:0]    o_m_sel;
    logic          i_m_ack, i_m_stall, i_m_err;
    logic [31:0]   i_m_data;

    bus_downsizer #(.AW(AW), .LGLANES(2)) dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_s_cyc(i_s_cyc), .i_s_stb(i_s_stb), .i_s_we(i_s_we),
        .i_s_addr(i_s_addr), .i_s_data(i_s_data), .i_s_sel(i_s_sel),
        .o_s_ack(o_s_ack), .o_s_stall(o_s_stall), .o_s_err(o_s_err), .o_s_data(o_s_data),
        .o_m_cyc(o_m_cyc), .o_m_stb(o_m_stb), .o_m_we(o_m_we),
        .o_m_addr(o_m_addr), .o_m_data(o_m_data), .o_m_sel(o_m_sel),
        .i_m_ack(i_m_ack), .i_m_stall(i_m_stall), .i_m_err(i_m_err), .i_m_data(i_m_data)
    );

    always #5 i_clk = ~i_clk;

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Responder state and transaction log
    logic          prev_fire = 1'b0;
    logic [1:0]    prev_lane = 2'd0;
    int            issue_no = 0, ack_no = 0, cyc_no = 0;
    int            stall_at = -1, stall_left = 0, err_at = -1, stalls_applied = 0;
    int            ack_pulses = 0, err_pulses = 0, hold_err = 0;
    bit            cyc_seen = 1'b0;
    logic          was_stalled = 1'b0;
    logic [AW+1:0] held_addr;
    logic [31:0]   held_data;
    logic [AW+1:0] log_addr[$];
    logic [31:0]   log_data[$];
    logic [3:0]    log_sel[$];
    logic          log_we[$];
    int            log_cyc[$];

    // Narrow slave: acks one cycle after acceptance, lane L returns 0x11111111*(L+1)
    initial begin
        i_m_ack = 1'b0; i_m_err = 1'b0; i_m_stall = 1'b0; i_m_data = '0;
        forever begin
            @(negedge i_clk);
            cyc_no++;
            if (o_s_ack === 1'b1) ack_pulses++;
            if (o_s_err === 1'b1) err_pulses++;
            if (o_m_cyc === 1'b1) cyc_seen = 1'b1;
            if (was_stalled && o_m_stb === 1'b1 && (o_m_addr !== held_addr || o_m_data !== held_data))
                hold_err++;
            i_m_ack = 1'b0;
            i_m_err = 1'b0;
            if (prev_fire) begin
                if (ack_no == err_at) i_m_err = 1'b1;
                else begin
                    i_m_ack  = 1'b1;
                    i_m_data = 32'h11111111 * (32'(prev_lane) + 32'd1);
                end
                ack_no++;
            end
            if (o_m_stb === 1'b1 && issue_no == stall_at && stall_left > 0) begin
                i_m_stall = 1'b1;
                stall_left--;
                stalls_applied++;
            end else begin
                i_m_stall = 1'b0;
            end
            was_stalled = i_m_stall;
            held_addr   = o_m_addr;
            held_data   = o_m_data;
            prev_fire   = (o_m_cyc === 1'b1) && (o_m_stb === 1'b1) && !i_m_stall;
            if (prev_fire) begin
                prev_lane = o_m_addr[1:0];
                log_addr.push_back(o_m_addr);
                log_data.push_back(o_m_data);
                log_sel.push_back(o_m_sel);
                log_we.push_back(o_m_we);
                log_cyc.push_back(cyc_no);
                issue_no++;
            end
            if (o_m_cyc !== 1'b1 && !prev_fire) begin
                issue_no = 0;
                ack_no   = 0;
            end
        end
    end

    function automatic logic [127:0] log_a(input int i);
        return (i < log_addr.size()) ? 128'(log_addr[i]) : '1;
    endfunction
    function automatic logic [127:0] log_d(input int i);
        return (i < log_data.size()) ? 128'(log_data[i]) : '1;
    endfunction
    function automatic logic [127:0] log_s(input int i);
        return (i < log_sel.size()) ? 128'(log_sel[i]) : '1;
    endfunction
    function automatic logic [127:0] log_w(input int i);
        return (i < log_we.size()) ? 128'(log_we[i]) : '1;
    endfunction

    // One wide request; waits (bounded) for ack or err
    task automatic run_req(input logic we, input logic [AW-1:0] addr, input logic [127:0] data,
                           input logic [15:0] sel, output int lat, output logic got_ack,
                           output logic got_err, output logic [127:0] rd);
        @(negedge i_clk);
        log_addr.delete(); log_data.delete(); log_sel.delete(); log_we.delete(); log_cyc.delete();
        i_s_cyc = 1'b1; i_s_stb = 1'b1; i_s_we = we;
        i_s_addr = addr; i_s_data = data; i_s_sel = sel;
        lat = 0; got_ack = 1'b0; got_err = 1'b0; rd = '0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge i_clk);
            if (k == 1) i_s_stb = 1'b0;
            if (o_s_ack === 1'b1 || o_s_err === 1'b1) begin
                lat = k; got_ack = o_s_ack; got_err = o_s_err; rd = o_s_data;
                break;
            end
        end
        check("req_done", 128'(got_ack | got_err), 128'd1);
        i_s_cyc = 1'b0;
    endtask

    int           lat, base_a, base_e;
    logic         ga, ge;
    logic [127:0] rd;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        i_reset = 1'b1; i_s_cyc = 1'b0; i_s_stb = 1'b0; i_s_we = 1'b0;
        i_s_addr = '0; i_s_data = '0; i_s_sel = '0;
        repeat (3) @(negedge i_clk);
        check("rst_m_cyc", 128'(o_m_cyc), 128'd0);
        check("rst_m_stb", 128'(o_m_stb), 128'd0);
        check("rst_s_ack", 128'(o_s_ack), 128'd0);
        check("rst_s_err", 128'(o_s_err), 128'd0);
        check("rst_s_stall", 128'(o_s_stall), 128'd0);
        check("rst_s_data", o_s_data, 128'd0);
        i_reset = 1'b0;
        repeat (2) @(negedge i_clk);

        // Full-width read
        base_a = ack_pulses;
        run_req(1'b0, 28'h0000010, 128'd0, 16'hFFFF, lat, ga, ge, rd);
        check("rd_ack", 128'(ga), 128'd1);
        check("rd_lat", 128'(lat), 128'd6);
        check("rd_data", rd, 128'h11111111_22222222_33333333_44444444);
        check("rd_nissue", 128'(log_addr.size()), 128'd4);
        for (int i = 0; i < 4; i++) begin
            check("rd_addr", log_a(i), 128'(30'h40 + i));
            check("rd_sel", log_s(i), 128'hF);
            check("rd_we", log_w(i), 128'd0);
        end
        if (log_cyc.size() == 4)
            check("rd_consec", 128'(log_cyc[3] - log_cyc[0]), 128'd3);
        repeat (2) @(negedge i_clk);
        check("rd_one_ack", 128'(ack_pulses - base_a), 128'd1);

        // Sparse write: lanes 1 and 3 only
        base_a = ack_pulses;
        run_req(1'b1, 28'h0000123, 128'hAAAAAAAA_BBBBBBBB_CCCCCCCC_DDDDDDDD, 16'h0F0F, lat, ga, ge, rd);
        check("wr_ack", 128'(ga), 128'd1);
        check("wr_lat", 128'(lat), 128'd4);
        check("wr_nissue", 128'(log_addr.size()), 128'd2);
        check("wr_addr0", log_a(0), 128'h48D);
        check("wr_data0", log_d(0), 128'hBBBBBBBB);
        check("wr_sel0", log_s(0), 128'hF);
        check("wr_we0", log_w(0), 128'd1);
        check("wr_addr1", log_a(1), 128'h48F);
        check("wr_data1", log_d(1), 128'hDDDDDDDD);
        check("wr_sel1", log_s(1), 128'hF);
        check("wr_rdata", rd, 128'h00000000_22222222_00000000_44444444);
        repeat (2) @(negedge i_clk);
        check("wr_one_ack", 128'(ack_pulses - base_a), 128'd1);

        // Three stall cycles on the second lane
        stall_at = 1; stall_left = 3; stalls_applied = 0; hold_err = 0;
        run_req(1'b1, 28'h0000200, 128'h01234567_89ABCDEF_FEDCBA98_76543210, 16'hFFFF, lat, ga, ge, rd);
        stall_at = -1;
        check("st_ack", 128'(ga), 128'd1);
        check("st_lat", 128'(lat), 128'd9);
        check("st_stalls", 128'(stalls_applied), 128'd3);
        check("st_hold", 128'(hold_err), 128'd0);
        check("st_nissue", 128'(log_addr.size()), 128'd4);
        check("st_addr1", log_a(1), 128'h801);
        check("st_data1", log_d(1), 128'h89ABCDEF);
        check("st_data3", log_d(3), 128'h76543210);
        check("st_rdata", rd, 128'h11111111_22222222_33333333_44444444);

        // Error on the second ack
        repeat (2) @(negedge i_clk);
        base_a = ack_pulses; base_e = err_pulses;
        err_at = 1;
        run_req(1'b0, 28'h0000010, 128'd0, 16'hFFFF, lat, ga, ge, rd);
        check("er_err", 128'(ge), 128'd1);
        check("er_noack", 128'(ga), 128'd0);
        check("er_lat", 128'(lat), 128'd4);
        check("er_m_cyc", 128'(o_m_cyc), 128'd0);
        check("er_m_stb", 128'(o_m_stb), 128'd0);
        @(negedge i_clk);
        check("er_pulse", 128'(o_s_err), 128'd0);
        err_at = -1;
        repeat (3) @(negedge i_clk);
        check("er_ack_cnt", 128'(ack_pulses - base_a), 128'd0);
        check("er_err_cnt", 128'(err_pulses - base_e), 128'd1);

        // Normal request after the error
        run_req(1'b0, 28'h0000011, 128'd0, 16'hF000, lat, ga, ge, rd);
        check("fu_ack", 128'(ga), 128'd1);
        check("fu_lat", 128'(lat), 128'd3);
        check("fu_addr", log_a(0), 128'h44);
        check("fu_rdata", rd, 128'h11111111_00000000_00000000_00000000);

        // Abort by dropping i_s_cyc mid-BUSY
        repeat (2) @(negedge i_clk);
        base_a = ack_pulses; base_e = err_pulses;
        i_s_cyc = 1'b1; i_s_stb = 1'b1; i_s_we = 1'b0; i_s_addr = 28'h0000030; i_s_sel = 16'hFFFF;
        @(negedge i_clk);
        i_s_stb = 1'b0;
        check("ab_busy", 128'(o_s_stall), 128'd1);
        @(negedge i_clk);
        i_s_cyc = 1'b0;
        @(negedge i_clk);
        check("ab_m_cyc", 128'(o_m_cyc), 128'd0);
        check("ab_m_stb", 128'(o_m_stb), 128'd0);
        check("ab_idle", 128'(o_s_stall), 128'd0);
        repeat (5) @(negedge i_clk);
        check("ab_ack_cnt", 128'(ack_pulses - base_a), 128'd0);
        check("ab_err_cnt", 128'(err_pulses - base_e), 128'd0);

        // Reset mid-BUSY with i_s_cyc still high
        base_a = ack_pulses; base_e = err_pulses;
        i_s_cyc = 1'b1; i_s_stb = 1'b1; i_s_we = 1'b0; i_s_addr = 28'h0000040; i_s_sel = 16'hFFFF;
        @(negedge i_clk);
        i_s_stb = 1'b0;
        @(negedge i_clk);
        i_reset = 1'b1;
        @(negedge i_clk);
        check("mr_m_cyc", 128'(o_m_cyc), 128'd0);
        check("mr_m_stb", 128'(o_m_stb), 128'd0);
        check("mr_s_ack", 128'(o_s_ack), 128'd0);
        check("mr_s_err", 128'(o_s_err), 128'd0);
        check("mr_s_stall", 128'(o_s_stall), 128'd0);
        check("mr_s_data", o_s_data, 128'd0);
        i_reset = 1'b0;
        i_s_cyc = 1'b0;
        repeat (5) @(negedge i_clk);
        check("mr_ack_cnt", 128'(ack_pulses - base_a), 128'd0);
        check("mr_err_cnt", 128'(err_pulses - base_e), 128'd0);

        // Empty select: immediate ack, no master cycle
        run_req(1'b1, 28'h0000055, 128'hFFFF, 16'hF000, lat, ga, ge, rd);
        repeat (2) @(negedge i_clk);
        cyc_seen = 1'b0;
        run_req(1'b0, 28'h0000066, 128'd0, 16'h0000, lat, ga, ge, rd);
        check("z_ack", 128'(ga), 128'd1);
        check("z_lat", 128'(lat), 128'd1);
        check("z_data", rd, 128'd0);
        check("z_nissue", 128'(log_addr.size()), 128'd0);
        repeat (2) @(negedge i_clk);
        check("z_no_cyc", 128'(cyc_seen), 128'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
